// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory command front end.
package mem_ctrl_pkg;

    localparam int unsigned CYCLE_W = 32;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned MAX_REQ = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               we;
        logic [DATA_W-1:0]  data;
        logic [ID_W-1:0]    id;
        logic [CYCLE_W-1:0] cycle_count;
    } mem_request_t;

    // Lowest set index of vec; MAX_REQ when vec is empty.
    function automatic int unsigned prio_pick(input logic [MAX_REQ-1:0] vec);
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) return i;
        end
        return MAX_REQ;
    endfunction

endpackage

// File: rtl/mem_sched_pacer.sv
// Paces ready->pending transfers: minimum issue gap plus in-flight cap.
module mem_sched_pacer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned ISSUE_GAP    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ready_empty,
    input  logic                             pop,
    output logic                             transfer,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);

    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    logic [GAP_W-1:0] gap_cnt;
    logic [INF_W-1:0] inflight_q;

    assign transfer = !ready_empty && (inflight_q < INF_W'(MAX_INFLIGHT)) && (gap_cnt == '0);
    assign inflight = inflight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (transfer) begin
            gap_cnt <= GAP_W'(ISSUE_GAP - 1);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            unique case ({transfer, pop})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(pop && inflight_q == '0));

endmodule

// File: rtl/mem_cmd_scheduler.sv
// Front-end scheduler: arbitrates requesters onto the queue enqueue port and paces transfers.
// Optional starvation override is built when MEM_SCHED_AGING_EN is defined.
module mem_cmd_scheduler
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned ISSUE_GAP    = 1,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [NUM_REQ-1:0]                  req_valid_in,
    input  mem_request_t [NUM_REQ-1:0]          req_in,
    output logic [NUM_REQ-1:0]                  req_ready_out,
    output logic                                q_enqueue_out,
    output mem_request_t                        q_req_out,
    input  logic                                q_full_in,
    input  logic                                q_ready_empty_in,
    output logic                                q_transfer_out,
    input  logic                                q_promote_in,
    output logic                                q_promote_ready_out,
    input  logic                                resp_ready_in,
    output logic [CYCLE_W-1:0]                  cycle_count_out,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_out
);

    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_INFLIGHT < 1 || ISSUE_GAP < 1 || STARVE_LIMIT < 1)
    begin : g_bad_cfg
        $error("mem_cmd_scheduler: illegal parameter set");
    end

    logic [CYCLE_W-1:0] cycle_cnt;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic [MAX_REQ-1:0] pick_vec;
    int unsigned        winner;
    mem_request_t       sel;
    logic               transfer;
    logic [INF_W-1:0]   inflight;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cycle_cnt <= '0;
        else           cycle_cnt <= cycle_cnt + 1'b1;
    end

`ifdef MEM_SCHED_AGING_EN
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0]  wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starving;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!req_valid_in[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_W'(STARVE_LIMIT))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        starving = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            starving[i] = req_valid_in[i] && (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
    end

    // Starved requesters form the candidate set; fixed priority then applies within it.
    assign cand = (|starving) ? starving : req_valid_in;
`else
    assign cand = req_valid_in;
`endif

    always_comb begin
        pick_vec                = '0;
        pick_vec[NUM_REQ-1:0]   = cand;
        winner                  = prio_pick(pick_vec);
        grant                   = '0;
        sel                     = '0;
        if (!q_full_in) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (winner == i) begin
                    grant[i] = 1'b1;
                    sel      = req_in[i];
                end
            end
        end
        if (|grant) sel.cycle_count = cycle_cnt;
    end

    mem_sched_pacer #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .ISSUE_GAP    (ISSUE_GAP)
    ) u_pacer (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .ready_empty (q_ready_empty_in),
        .pop         (q_promote_in && resp_ready_in),
        .transfer    (transfer),
        .inflight    (inflight)
    );

    // Combinational outputs are forced low while reset is asserted.
    assign req_ready_out       = rst_n_in ? grant : '0;
    assign q_enqueue_out       = rst_n_in && (|grant);
    assign q_req_out           = rst_n_in ? sel : '0;
    assign q_transfer_out      = rst_n_in && transfer;
    assign q_promote_ready_out = rst_n_in && resp_ready_in;
    assign cycle_count_out     = cycle_cnt;
    assign inflight_out        = inflight;

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Scoreboard bench for mem_cmd_scheduler; honours MEM_SCHED_AGING_EN in its reference model.
module tb_mem_cmd_scheduler;
    import mem_ctrl_pkg::*;

    localparam int NR  = 4;
    localparam int MI  = 3;
    localparam int GAP = 3;
    localparam int SL  = 4;
    localparam int IW  = $clog2(MI + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NR-1:0]        valid = '0;
    mem_request_t [NR-1:0] reqs = '0;
    logic [NR-1:0]        ready;
    logic                 enq;
    mem_request_t         qreq;
    logic                 full = 1'b0, empty = 1'b1, prom = 1'b0, resp = 1'b0;
    logic                 xfer, prdy;
    logic [31:0]          cc;
    logic [IW-1:0]        infl;

    always #5 clk = ~clk;

    mem_cmd_scheduler #(
        .NUM_REQ(NR), .MAX_INFLIGHT(MI), .ISSUE_GAP(GAP), .STARVE_LIMIT(SL)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid), .req_in(reqs),
        .req_ready_out(ready), .q_enqueue_out(enq), .q_req_out(qreq),
        .q_full_in(full), .q_ready_empty_in(empty), .q_transfer_out(xfer),
        .q_promote_in(prom), .q_promote_ready_out(prdy), .resp_ready_in(resp),
        .cycle_count_out(cc), .inflight_out(infl)
    );

    typedef struct packed {
        logic          in_rst;
        logic [NR-1:0] grant;
        logic          enq;
        logic          xfer;
        logic          prdy;
        logic [31:0]   cc;
        logic [IW-1:0] infl;
    } exp_t;

    exp_t         exp_q[$];
    mem_request_t cmd_q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model state: counts since reset, cycle of last transfer, consecutive wait cycles.
    logic [31:0]  m_cc;
    int           m_infl, m_n, m_last;
    int           m_wait[NR];
    bit           pend[NR];
    mem_request_t cmd[NR];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic mem_request_t rand_cmd();
        mem_request_t c;
        c.addr = ADDR_W'($urandom);
        c.we = 1'($urandom);
        c.data = $urandom;
        c.id = ID_W'($urandom);
        c.cycle_count = $urandom;
        return c;
    endfunction

    task automatic model_reset();
        m_cc = '0; m_infl = 0; m_n = 0; m_last = -GAP;
        for (int i = 0; i < NR; i++) m_wait[i] = 0;
    endtask

    task automatic step(input bit r, input bit f, input bit e, input bit p, input bit rr);
        exp_t ex;
        int   win;
        bit   t, pop;
        mem_request_t c;
        @(posedge clk); #1;
        if (r || m_infl == 0) p = 1'b0;
        rst_n = !r; full = f; empty = e; prom = p; resp = rr;
        for (int i = 0; i < NR; i++) begin
            valid[i] = pend[i];
            reqs[i]  = cmd[i];
        end
        ex = '0;
        if (r) begin
            ex.in_rst = 1'b1;
            model_reset();
            exp_q.push_back(ex);
            return;
        end
        win = -1;
        if (!f) begin
`ifdef MEM_SCHED_AGING_EN
            for (int i = 0; i < NR; i++) if (win < 0 && pend[i] && m_wait[i] >= SL) win = i;
`endif
            for (int i = 0; i < NR; i++) if (win < 0 && pend[i]) win = i;
        end
        t   = !e && (m_infl < MI) && (m_n - m_last >= GAP);
        pop = p && rr;
        if (win >= 0) begin
            ex.grant[win] = 1'b1;
            ex.enq = 1'b1;
            c = cmd[win];
            c.cycle_count = m_cc;
            cmd_q.push_back(c);
        end
        ex.xfer = t; ex.prdy = rr; ex.cc = m_cc; ex.infl = IW'(m_infl);
        exp_q.push_back(ex);
        m_infl = m_infl + int'(t) - int'(pop);
        if (t) m_last = m_n;
        m_n++;
        m_cc = m_cc + 1;
        for (int i = 0; i < NR; i++)
            m_wait[i] = (pend[i] && win != i) ? ((m_wait[i] < SL) ? m_wait[i] + 1 : SL) : 0;
        if (win >= 0) pend[win] = 1'b0;
    endtask

    // Monitor: pops one expected record per cycle and one command per observed enqueue.
    always @(negedge clk) begin
        exp_t ex;
        mem_request_t c;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("grant", 128'(ready), 128'(ex.grant));
            check("enqueue", 128'(enq), 128'(ex.enq));
            check("transfer", 128'(xfer), 128'(ex.xfer));
            check("promote_ready", 128'(prdy), 128'(ex.prdy));
            check("cycle_count", 128'(cc), 128'(ex.cc));
            check("inflight", 128'(infl), 128'(ex.infl));
            if (ex.in_rst) check("req_in_reset", 128'(qreq), 128'(0));
            if (enq) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_enqueue: got enqueue expected none at %0t", $time);
                end else begin
                    c = cmd_q.pop_front();
                    check("q_req", 128'(qreq), 128'(c));
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b1; cmd[i] = rand_cmd(); end
        // Reset held three cycles with all requesters valid.
        repeat (3) step(1, 0, 0, 1, 1);
        // Fixed priority on 4'b1010, then backpressure release.
        pend[0] = 1'b0; pend[2] = 1'b0;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < NR; i++) if (!pend[i]) begin pend[i] = 1'b1; cmd[i] = rand_cmd(); end
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // Transfers against gap and in-flight cap, then pops.
        repeat (12) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        // req0 keeps requesting while req3 waits.
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        pend[3] = 1'b1; cmd[3] = rand_cmd();
        repeat (14) begin
            if (!pend[0]) begin pend[0] = 1'b1; cmd[0] = rand_cmd(); end
            step(0, 0, 1, 0, 0);
        end
        // Randomised traffic with a mid-run reset.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 1) == 0) begin pend[i] = 1'b1; cmd[i] = rand_cmd(); end
            if (k == 700 || k == 701)
                step(1, 0, 0, 1, 1);
            else
                step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 0, $urandom_range(0, 9) < 7);
        end
        @(posedge clk); @(negedge clk); #1;
        check("exp_queue_drained", 128'(exp_q.size()), 128'(0));
        check("cmd_queue_drained", 128'(cmd_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
